// File: rtl/sync_fifo_param.sv
// Single-clock first-word-fall-through FIFO with rdy/vld handshakes on both
// sides, parametrised depth (need not be a power of 2), occupancy count,
// almost-full/almost-empty flags and a synchronous flush.
module sync_fifo_param #(
   parameter int unsigned width    = 32,
   parameter int unsigned depth    = 8,
   parameter int unsigned cntw     = 4,
   parameter int unsigned af_level = 6,
   parameter int unsigned ae_level = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in1_vld,
   output logic              in1_rdy,
   input  logic [width-1:0]  in1_dat,
   output logic              out1_vld,
   input  logic              out1_rdy,
   output logic [width-1:0]  out1_dat,
   output logic [cntw-1:0]   count,
   output logic              almost_full,
   output logic              almost_empty
);

   localparam int unsigned PTRW = (depth > 1) ? $clog2(depth) : 1;
   localparam logic [PTRW-1:0] PTR_LAST = PTRW'(depth - 1);
   localparam logic [cntw-1:0] CNT_FULL = cntw'(depth);
   localparam logic [cntw-1:0] CNT_AF   = cntw'(af_level);
   localparam logic [cntw-1:0] CNT_AE   = cntw'(ae_level);

   logic [width-1:0] mem [depth];
   logic [PTRW-1:0]  wr_ptr;
   logic [PTRW-1:0]  rd_ptr;
   logic             push;
   logic             pop;
   logic             clr;

   // Handshake qualifiers; both sides derive only from the count register.
   assign clr          = rst | flush;
   assign in1_rdy      = (count != CNT_FULL);
   assign out1_vld     = (count != '0);
   assign push         = in1_vld & in1_rdy;
   assign pop          = out1_vld & out1_rdy;
   assign almost_full  = (count >= CNT_AF);
   assign almost_empty = (count <= CNT_AE);

   // Head entry read; masked to zero while empty so reset shows a clean bus.
   assign out1_dat = out1_vld ? mem[rd_ptr] : '0;

   // Storage array; intentionally not cleared by reset or flush.
   always_ff @(posedge clk) begin
      if (push && !clr) begin
         mem[wr_ptr] <= in1_dat;
      end
   end

   // Pointers and occupancy; reset and flush discard same-cycle transfers.
   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTRW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTRW'(1);
         end
         if (push && !pop) begin
            count <= count + cntw'(1);
         end else if (pop && !push) begin
            count <= count - cntw'(1);
         end
      end
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: directed vector table on a depth-4 instance,
// then randomized backpressure on a depth-5 instance against a queue model.
module tb_sync_fifo_param;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // depth-4 instance
   logic       a_flush, a_ivld, a_irdy, a_ovld, a_ordy, a_af, a_ae;
   logic [7:0] a_idat, a_odat;
   logic [2:0] a_cnt;

   // depth-5 instance
   logic        b_flush, b_ivld, b_irdy, b_ovld, b_ordy, b_af, b_ae;
   logic [15:0] b_idat, b_odat;
   logic [2:0]  b_cnt;

   sync_fifo_param #(.width(8), .depth(4), .cntw(3), .af_level(3), .ae_level(1)) dut_a (
      .clk(clk), .rst(rst), .flush(a_flush),
      .in1_vld(a_ivld), .in1_rdy(a_irdy), .in1_dat(a_idat),
      .out1_vld(a_ovld), .out1_rdy(a_ordy), .out1_dat(a_odat),
      .count(a_cnt), .almost_full(a_af), .almost_empty(a_ae));

   sync_fifo_param #(.width(16), .depth(5), .cntw(3), .af_level(4), .ae_level(1)) dut_b (
      .clk(clk), .rst(rst), .flush(b_flush),
      .in1_vld(b_ivld), .in1_rdy(b_irdy), .in1_dat(b_idat),
      .out1_vld(b_ovld), .out1_rdy(b_ordy), .out1_dat(b_odat),
      .count(b_cnt), .almost_full(b_af), .almost_empty(b_ae));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   typedef struct {
      logic       rst, flush, vld;
      logic [7:0] dat;
      logic       rdy;
      int         cnt;
      logic       irdy, ovld;
      logic [7:0] odat;
      logic       af, ae, dchk;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, input logic f, input logic v, input logic [7:0] d,
                               input logic rd, input int c, input logic ir, input logic ov,
                               input logic [7:0] od, input logic af, input logic ae,
                               input logic dc);
      vec_t t;
      t.rst = r; t.flush = f; t.vld = v; t.dat = d; t.rdy = rd;
      t.cnt = c; t.irdy = ir; t.ovld = ov; t.odat = od; t.af = af; t.ae = ae; t.dchk = dc;
      tbl.push_back(t);
   endfunction

   // drive on negedge, let one posedge pass, sample on the following negedge
   task automatic step_a(input logic r, input logic f, input logic v, input logic [7:0] d,
                         input logic rd);
      rst = r; a_flush = f; a_ivld = v; a_idat = d; a_ordy = rd;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      a_flush = 0; a_ivld = 0; a_idat = 0; a_ordy = 0;
      b_flush = 0; b_ivld = 0; b_idat = 0; b_ordy = 0;

      //   rst fl vld dat    rdy cnt irdy ovld odat   af ae dchk
      // 1: reset and flags
      add(1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1, 1);
      add(1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1, 1);
      add(0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1, 1);
      // 2: fill to full, 5th push refused, head stays 0x11
      add(0, 0, 1, 8'h11, 0, 1, 1, 1, 8'h11, 0, 1, 1);
      add(0, 0, 1, 8'h22, 0, 2, 1, 1, 8'h11, 0, 0, 1);
      add(0, 0, 1, 8'h33, 0, 3, 1, 1, 8'h11, 1, 0, 1);
      add(0, 0, 1, 8'h44, 0, 4, 0, 1, 8'h11, 1, 0, 1);
      add(0, 0, 1, 8'hFF, 0, 4, 0, 1, 8'h11, 1, 0, 1);
      // 3: drain, then stream 0x55..0x5A across the pointer wrap
      add(0, 0, 0, 8'h00, 1, 3, 1, 1, 8'h22, 1, 0, 1);
      add(0, 0, 0, 8'h00, 1, 2, 1, 1, 8'h33, 0, 0, 1);
      add(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h44, 0, 1, 1);
      add(0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 1, 0);
      add(0, 0, 1, 8'h55, 1, 1, 1, 1, 8'h55, 0, 1, 1);
      add(0, 0, 1, 8'h56, 1, 1, 1, 1, 8'h56, 0, 1, 1);
      add(0, 0, 1, 8'h57, 1, 1, 1, 1, 8'h57, 0, 1, 1);
      add(0, 0, 1, 8'h58, 1, 1, 1, 1, 8'h58, 0, 1, 1);
      add(0, 0, 1, 8'h59, 1, 1, 1, 1, 8'h59, 0, 1, 1);
      add(0, 0, 1, 8'h5A, 1, 1, 1, 1, 8'h5A, 0, 1, 1);
      add(0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 1, 0);
      // 4: full with simultaneous pop; push of 0xB0 refused
      add(0, 0, 1, 8'hA1, 0, 1, 1, 1, 8'hA1, 0, 1, 1);
      add(0, 0, 1, 8'hA2, 0, 2, 1, 1, 8'hA1, 0, 0, 1);
      add(0, 0, 1, 8'hA3, 0, 3, 1, 1, 8'hA1, 1, 0, 1);
      add(0, 0, 1, 8'hA4, 0, 4, 0, 1, 8'hA1, 1, 0, 1);
      add(0, 0, 1, 8'hB0, 1, 3, 1, 1, 8'hA2, 1, 0, 1);
      add(0, 0, 0, 8'h00, 0, 3, 1, 1, 8'hA2, 1, 0, 1);
      add(0, 0, 0, 8'h00, 1, 2, 1, 1, 8'hA3, 0, 0, 1);
      add(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'hA4, 0, 1, 1);
      add(0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 1, 0);
      // 5: flush mid-stream discards 0x77; 0x88 is next out
      add(0, 0, 1, 8'hC1, 0, 1, 1, 1, 8'hC1, 0, 1, 1);
      add(0, 0, 1, 8'hC2, 0, 2, 1, 1, 8'hC1, 0, 0, 1);
      add(0, 1, 1, 8'h77, 1, 0, 1, 0, 8'h00, 0, 1, 0);
      add(0, 0, 1, 8'h88, 0, 1, 1, 1, 8'h88, 0, 1, 1);
      add(0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 1, 0);

      foreach (tbl[i]) begin
         step_a(tbl[i].rst, tbl[i].flush, tbl[i].vld, tbl[i].dat, tbl[i].rdy);
         chk($sformatf("v%0d_count", i), int'(a_cnt), tbl[i].cnt);
         chk($sformatf("v%0d_in1_rdy", i), int'(a_irdy), int'(tbl[i].irdy));
         chk($sformatf("v%0d_out1_vld", i), int'(a_ovld), int'(tbl[i].ovld));
         chk($sformatf("v%0d_almost_full", i), int'(a_af), int'(tbl[i].af));
         chk($sformatf("v%0d_almost_empty", i), int'(a_ae), int'(tbl[i].ae));
         if (tbl[i].dchk)
            chk($sformatf("v%0d_out1_dat", i), int'(a_odat), int'(tbl[i].odat));
      end

      // reset during a push and pop wins and discards both
      step_a(0, 0, 1, 8'hD1, 0);
      chk("rstmid_pre_count", int'(a_cnt), 1);
      step_a(1, 0, 1, 8'hD2, 1);
      chk("rstmid_count", int'(a_cnt), 0);
      chk("rstmid_vld", int'(a_ovld), 0);
      chk("rstmid_dat", int'(a_odat), 0);
      step_a(0, 0, 0, 8'h00, 0);
      chk("rstmid_idle_count", int'(a_cnt), 0);
      // empty FIFO: pushed word only visible after the push edge
      a_ivld = 1; a_idat = 8'hE5; a_ordy = 1;
      #1;
      chk("nobypass_vld", int'(a_ovld), 0);
      @(posedge clk);
      @(negedge clk);
      chk("latency_vld", int'(a_ovld), 1);
      chk("latency_dat", int'(a_odat), 8'hE5);
      a_ivld = 0;
      @(posedge clk);
      @(negedge clk);
      chk("latency_drain", int'(a_cnt), 0);
      a_ordy = 0;

      // randomized backpressure on depth-5 instance against a queue model
      begin
         logic [15:0] q[$];
         logic [15:0] prev_dat = '0;
         logic        prev_stall = 1'b0;
         int          popped = 0;
         int          cyc = 0;
         int          pv = 70, pr = 60;
         logic        exp_push, exp_pop;
         while (popped < 2000 && cyc < 30000) begin
            chk("rnd_count", int'(b_cnt), q.size());
            chk("rnd_in1_rdy", int'(b_irdy), int'(q.size() != 5));
            chk("rnd_out1_vld", int'(b_ovld), int'(q.size() != 0));
            chk("rnd_almost_full", int'(b_af), int'(q.size() >= 4));
            chk("rnd_almost_empty", int'(b_ae), int'(q.size() <= 1));
            chk("rnd_count_le_depth", int'(b_cnt <= 3'd5), 1);
            if (q.size() != 0) chk("rnd_out1_dat", int'(b_odat), int'(q[0]));
            if (prev_stall) chk("rnd_stall_stable", int'(b_odat), int'(prev_dat));
            if (cyc % 150 == 0) begin
               pv = int'($urandom_range(20, 95));
               pr = int'($urandom_range(20, 95));
            end
            b_ivld = ($urandom_range(0, 99) < pv);
            b_idat = 16'($urandom);
            b_ordy = ($urandom_range(0, 99) < pr);
            exp_push = b_ivld && (q.size() != 5);
            exp_pop  = b_ordy && (q.size() != 0);
            prev_stall = (q.size() != 0) && !b_ordy;
            prev_dat   = b_odat;
            @(posedge clk);
            if (exp_pop) begin
               void'(q.pop_front());
               popped++;
            end
            if (exp_push) q.push_back(b_idat);
            @(negedge clk);
            cyc++;
         end
         chk("rnd_words_delivered", popped, 2000);
         b_ivld = 0; b_ordy = 0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised-depth, first-word-fall-through FIFO with rdy/vld handshakes on both sides.
- Next-generation replacement for the one-entry toggle buffer, for same-domain buffering between Matchlib-style channel producers and consumers.
- Adds the following, which the one-entry buffer lacks:
  - configurable depth
  - occupancy count
  - almost-full and almost-empty flags
  - synchronous flush
  - full throughput: one push and one pop per cycle

Parameters:
- width, 32: data bits per entry.
- depth, 8: number of entries. Legal range is 2 to 256. Need not be a power of 2.
- cntw, 4: bit width of count. Must satisfy 2^cntw > depth.
- af_level, 6: almost_full asserts when count >= af_level. Legal range is 1 to depth.
- ae_level, 1: almost_empty asserts when count <= ae_level. Legal range is 0 to depth-1.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  synchronous clear of contents; same effect as rst on FIFO state.
- in1_vld  input  1  producer has data.
- in1_rdy  output  1  FIFO can accept data.
- in1_dat  input  width  write data.
- out1_vld  output  1  head entry is valid.
- out1_rdy  input  1  consumer accepts the head entry.
- out1_dat  output  width  head entry data.
- count  output  cntw  number of stored entries, 0 to depth.
- almost_full  output  1  count >= af_level.
- almost_empty  output  1  count <= ae_level.

Behaviour:
- Transfer rules:
  - push = in1_vld & in1_rdy. pop = out1_vld & out1_rdy. Both are sampled at posedge clk.
  - Neither side may depend combinationally on the other side's handshake.
  - in1_rdy = (count != depth). It is registered-derived and does not depend on out1_rdy, so a full FIFO refuses a push even when a pop occurs in the same cycle.
  - out1_vld = (count != 0). out1_dat = mem[rd_ptr], combinational read of the head entry.
- State:
  - mem[depth], wr_ptr, rd_ptr (each with range 0 to depth-1), count register.
  - Pointers wrap from depth-1 to 0 by explicit compare, not by power-of-2 masking.
- Reset or flush (rst=1 or flush=1 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Resulting outputs: in1_rdy=1, out1_vld=0, almost_empty=1, almost_full=0.
  - Any push or pop in that cycle is discarded.
  - out1_dat=0 after rst. After flush, out1_dat is don't-care while out1_vld=0.
  - mem contents are not cleared.
  - rst has priority over everything. flush has the same priority as rst.
- Latency:
  - A pushed word is visible at out1_dat/out1_vld the cycle after the push edge.
  - There is no same-cycle bypass when empty.
- Count update per posedge:
  - push only: count+1.
  - pop only: count-1.
  - both or neither: unchanged.
  - Simultaneous push and pop at count=0 cannot occur, because out1_vld=0.
  - At count=depth, push is blocked, so count never exceeds depth.
- Flags: almost_full and almost_empty are combinational from the count register.
- Data while stalled: out1_dat must remain stable while out1_vld=1 and out1_rdy=0. A push into a non-empty FIFO never alters the head entry.
- Ordering: strict FIFO order, with no loss or duplication across pointer wrap.
- Protocol errors: none are flagged. in1_vld may drop without a transfer, and in1_dat is ignored when no push occurs.

Test Plan:
1. Reset and flags (width=8, depth=4, af_level=3, ae_level=1).
   - Stimulus: rst=1 for 2 cycles, then release.
   - Required: count=0, in1_rdy=1, out1_vld=0, almost_empty=1, almost_full=0, out1_dat=0.
2. Fill to full.
   - Stimulus: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with out1_rdy=0.
   - Required after the 3rd push: almost_full=1.
   - Required after the 4th push: count=4, in1_rdy=0.
   - Required: a 5th in1_vld with 0xFF is refused, and out1_dat stays 0x11 throughout.
3. Drain and wrap.
   - Stimulus: from full, out1_rdy=1 for 4 cycles; then push 0x55 to 0x5A while popping continuously.
   - Required: outputs 0x11, 0x22, 0x33, 0x44, then 0x55 to 0x5A in order, with pointers wrapping.
   - Required: count is 0 when idle. Once streaming, count holds steady at 1 with one transfer per cycle on each side.
4. Full with a simultaneous pop.
   - Stimulus: at count=4, in1_vld=1 and out1_rdy=1 in the same cycle.
   - Required: pop occurs and push is refused; count becomes 3; in1_rdy=1 on the next cycle.
5. Flush mid-stream.
   - Stimulus: at count=2, assert flush together with in1_vld=1 (data 0x77) and out1_rdy=1.
   - Required next cycle: count=0, out1_vld=0. 0x77 is never delivered.
   - Required: the next push of 0x88 is delivered first.
6. Randomized backpressure (depth=5, non-power-of-2).
   - Stimulus: random in1_vld/out1_rdy over 2000 words.
   - Required: scoreboard matches exactly; count never exceeds 5; out1_dat is stable during stalls.
